// File: rtl/hazard_ctrl_unit.sv
// rtl/hazard_ctrl_unit.sv - pipeline hazard/stall/forward controller; optional perf counters via HAZARD_PERF_CNT_EN
module hazard_ctrl_unit #(
  parameter int REG_AW     = 5,
  parameter int MULDIV_LAT = 4,
  parameter int CNT_W      = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] Rs1D,
  input  logic [REG_AW-1:0] Rs2D,
  input  logic [REG_AW-1:0] Rs1E,
  input  logic [REG_AW-1:0] Rs2E,
  input  logic [REG_AW-1:0] RdE,
  input  logic [1:0]        ResultSrcE,
  input  logic              PCSrcE,
  input  logic              MulDivE,
  input  logic [REG_AW-1:0] RdM,
  input  logic [REG_AW-1:0] RdW,
  input  logic              RegWriteM,
  input  logic              RegWriteW,
  input  logic              MemReqM,
  input  logic              MemReadyM,
  output logic              StallF,
  output logic              StallD,
  output logic              StallE,
  output logic              StallM,
  output logic              FlushD,
  output logic              FlushE,
  output logic              FlushM,
  output logic              FlushW,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic              MulDivBusy,
  output logic [CNT_W-1:0]  StallCycles,
  output logic [CNT_W-1:0]  FlushCycles
);

  localparam int CntW = ($clog2(MULDIV_LAT) < 1) ? 1 : $clog2(MULDIV_LAT);
  localparam bit MdMulti = (MULDIV_LAT > 1);
  localparam logic [CntW-1:0] CntLoad = CntW'((MULDIV_LAT > 1) ? (MULDIV_LAT - 2) : 0);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t          state, stateNext;
  logic [CntW-1:0] cnt, cntNext;
  logic            memStall, lwStall, mdStall;

  // Operand forwarding: M stage result has priority over W; x0 never forwards
  assign ForwardAE = (Rs1E != '0 && Rs1E == RdM && RegWriteM) ? 2'b10 :
                     (Rs1E != '0 && Rs1E == RdW && RegWriteW) ? 2'b01 : 2'b00;
  assign ForwardBE = (Rs2E != '0 && Rs2E == RdM && RegWriteM) ? 2'b10 :
                     (Rs2E != '0 && Rs2E == RdW && RegWriteW) ? 2'b01 : 2'b00;

  // Hazard sources; a taken branch in E discards the dependent instruction, so no load-use bubble
  assign memStall = MemReqM & ~MemReadyM;
  assign lwStall  = (ResultSrcE == 2'b01) & (RdE != '0) &
                    ((Rs1D == RdE) | (Rs2D == RdE)) & ~PCSrcE;

  assign StallM = memStall;
  assign FlushW = memStall;
  assign StallE = memStall | mdStall;
  assign StallD = StallE | lwStall;
  assign StallF = StallD;
  assign FlushM = mdStall & ~memStall;
  assign FlushE = ~StallE & (lwStall | PCSrcE);
  assign FlushD = ~StallE & PCSrcE;
  assign MulDivBusy = (state == BUSY);

  // Mul/div occupancy FSM state register; reset drops BUSY immediately
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= stateNext;
      cnt   <= cntNext;
    end
  end

  // Next state and mdStall; a memory wait freezes the countdown
  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    mdStall   = 1'b0;
    case (state)
      IDLE: begin
        mdStall = MulDivE & MdMulti;
        if (MulDivE && MdMulti && !memStall) begin
          stateNext = BUSY;
          cntNext   = CntLoad;
        end
      end
      BUSY: begin
        mdStall = (cnt != '0);
        if (!memStall) begin
          if (cnt == '0) stateNext = IDLE;
          else           cntNext   = cnt - CntW'(1);
        end
      end
      default: stateNext = IDLE;
    endcase
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stallCnt, flushCnt;

  // Free-running wrap-around counts of front-end stall and E-flush cycles
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stallCnt <= '0;
      flushCnt <= '0;
    end else begin
      if (StallF) stallCnt <= stallCnt + CNT_W'(1);
      if (FlushE) flushCnt <= flushCnt + CNT_W'(1);
    end
  end

  assign StallCycles = stallCnt;
  assign FlushCycles = flushCnt;
`else
  assign StallCycles = '0;
  assign FlushCycles = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// tb/tb_hazard_ctrl_unit.sv - self-checking bench for hazard_ctrl_unit
module tb_hazard_ctrl_unit;
  localparam int LAT = 4;
`ifdef HAZARD_PERF_CNT_EN
  localparam bit PerfEn = 1'b1;
`else
  localparam bit PerfEn = 1'b0;
`endif

  typedef struct {
    logic [4:0] rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
    logic [1:0] resultSrcE;
    logic pcSrcE, mulDivE, regWriteM, regWriteW, memReqM, memReadyM;
  } stim_t;

  typedef struct {
    stim_t s;
    logic [11:0] exp;
  } vec_t;

  logic clk = 1'b0, reset = 1'b1;
  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic [1:0] ResultSrcE;
  logic PCSrcE, MulDivE, RegWriteM, RegWriteW, MemReqM, MemReadyM;
  logic StallF, StallD, StallE, StallM, FlushD, FlushE, FlushM, FlushW, MulDivBusy;
  logic [1:0] ForwardAE, ForwardBE;
  logic [31:0] StallCycles, FlushCycles;
  logic [11:0] dutPack;

  int checks = 0, errors = 0;
  int mdLeft = 0;
  logic [31:0] expStallCnt = 0, expFlushCnt = 0;

  always #5 clk = ~clk;

  hazard_ctrl_unit #(.REG_AW(5), .MULDIV_LAT(LAT), .CNT_W(32)) dut (
    .clk(clk), .reset(reset),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
    .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE), .MulDivE(MulDivE),
    .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MemReqM(MemReqM), .MemReadyM(MemReadyM),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM), .FlushW(FlushW),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .MulDivBusy(MulDivBusy),
    .StallCycles(StallCycles), .FlushCycles(FlushCycles)
  );

  assign dutPack = {ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
                    FlushD, FlushE, FlushM, FlushW};

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  function automatic stim_t mk(input logic [4:0] rs1D, rs2D, rs1E, rs2E, rdE,
                               input logic [1:0] rs, input logic pc,
                               input logic [4:0] rdM, input logic rwM,
                               input logic [4:0] rdW, input logic rwW,
                               input logic mreq, mrdy);
    stim_t s;
    s.rs1D = rs1D; s.rs2D = rs2D; s.rs1E = rs1E; s.rs2E = rs2E; s.rdE = rdE;
    s.resultSrcE = rs; s.pcSrcE = pc; s.mulDivE = 1'b0;
    s.rdM = rdM; s.regWriteM = rwM; s.rdW = rdW; s.regWriteW = rwW;
    s.memReqM = mreq; s.memReadyM = mrdy;
    return s;
  endfunction

  function automatic logic [1:0] refFwd(input logic [4:0] rs, rdM, input logic rwM,
                                        input logic [4:0] rdW, input logic rwW);
    if (rs != 0 && rs == rdM && rwM) return 2'b10;
    if (rs != 0 && rs == rdW && rwW) return 2'b01;
    return 2'b00;
  endfunction

  task automatic drive(input stim_t s);
    Rs1D = s.rs1D; Rs2D = s.rs2D; Rs1E = s.rs1E; Rs2E = s.rs2E; RdE = s.rdE;
    ResultSrcE = s.resultSrcE; PCSrcE = s.pcSrcE; MulDivE = s.mulDivE;
    RdM = s.rdM; RdW = s.rdW; RegWriteM = s.regWriteM; RegWriteW = s.regWriteW;
    MemReqM = s.memReqM; MemReadyM = s.memReadyM;
  endtask

  // One pipeline cycle: drive, compare against the reference model (and an optional
  // hand-derived expectation), then advance the model across the coming clock edge
  task automatic runCycle(input stim_t s, input bit hasExp, input logic [11:0] exp,
                          input logic expBusy, input string name);
    logic memS, lw, md, stE, stF, flM, flE, flD;
    logic [11:0] model;
    @(negedge clk);
    drive(s);
    #1;
    memS = s.memReqM & ~s.memReadyM;
    lw   = (s.resultSrcE == 2'b01) && (s.rdE != 0) &&
           (s.rs1D == s.rdE || s.rs2D == s.rdE) && !s.pcSrcE;
    md   = (mdLeft == 0) ? (s.mulDivE && LAT > 1) : (mdLeft > 1);
    stE  = memS | md;
    stF  = stE | lw;
    flM  = md & ~memS;
    flE  = ~stE & (lw | s.pcSrcE);
    flD  = ~stE & s.pcSrcE;
    model = {refFwd(s.rs1E, s.rdM, s.regWriteM, s.rdW, s.regWriteW),
             refFwd(s.rs2E, s.rdM, s.regWriteM, s.rdW, s.regWriteW),
             stF, stF, stE, memS, flD, flE, flM, memS};
    check({name, "_model"}, dutPack, model);
    check({name, "_busy"}, MulDivBusy, mdLeft > 0);
    check({name, "_stallcnt"}, StallCycles, PerfEn ? expStallCnt : 32'd0);
    check({name, "_flushcnt"}, FlushCycles, PerfEn ? expFlushCnt : 32'd0);
    if (hasExp) begin
      check({name, "_table"}, dutPack, exp);
      check({name, "_tbusy"}, MulDivBusy, expBusy);
    end
    if (!memS) begin
      if (mdLeft == 0) begin
        if (s.mulDivE && LAT > 1) mdLeft = LAT - 1;
      end else begin
        mdLeft--;
      end
    end
    if (stF) expStallCnt++;
    if (flE) expFlushCnt++;
  endtask

  task automatic doReset();
    reset = 1'b1;
    #1;
    check("rst_busy", MulDivBusy, 1'b0);
    check("rst_stallE", StallE, 1'b0);
    check("rst_stallcnt", StallCycles, 32'd0);
    check("rst_flushcnt", FlushCycles, 32'd0);
    mdLeft = 0;
    expStallCnt = 0;
    expFlushCnt = 0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  vec_t  vecs[13];
  stim_t z, s, mdS, memMd;

  initial begin
    z = mk(0,0,0,0,0, 2'b00, 0, 0,0, 0,0, 0,0);
    drive(z);
    #1;
    check("reset_outputs", dutPack, 12'd0);
    check("reset_busy", MulDivBusy, 1'b0);
    check("reset_cnts", {StallCycles, FlushCycles}, 64'd0);
    @(negedge clk);
    reset = 1'b0;

    vecs[0]  = '{z, 12'b00_00_0000_0000};
    vecs[1]  = '{mk(0,0,5,0,0, 2'b00, 0, 5,1, 5,1, 0,0), 12'b10_00_0000_0000};
    vecs[2]  = '{mk(0,0,0,0,0, 2'b00, 0, 5,1, 5,1, 0,0), 12'b00_00_0000_0000};
    vecs[3]  = '{mk(0,0,3,3,0, 2'b00, 0, 4,1, 3,1, 0,0), 12'b01_01_0000_0000};
    vecs[4]  = '{mk(0,0,0,6,0, 2'b00, 0, 6,0, 6,0, 0,0), 12'b00_00_0000_0000};
    vecs[5]  = '{mk(0,7,0,0,7, 2'b01, 0, 0,0, 0,0, 0,0), 12'b00_00_1100_0100};
    vecs[6]  = '{mk(0,7,0,0,7, 2'b01, 1, 0,0, 0,0, 0,0), 12'b00_00_0000_1100};
    vecs[7]  = '{mk(0,0,0,0,0, 2'b01, 0, 0,0, 0,0, 0,0), 12'b00_00_0000_0000};
    vecs[8]  = '{mk(7,0,0,0,7, 2'b10, 0, 0,0, 0,0, 0,0), 12'b00_00_0000_0000};
    vecs[9]  = '{mk(0,0,0,0,0, 2'b00, 0, 0,0, 0,0, 1,0), 12'b00_00_1111_0001};
    vecs[10] = '{mk(0,0,0,0,0, 2'b00, 0, 0,0, 0,0, 1,1), 12'b00_00_0000_0000};
    vecs[11] = '{mk(0,0,0,0,0, 2'b00, 1, 0,0, 0,0, 1,0), 12'b00_00_1111_0001};
    vecs[12] = '{mk(7,0,0,0,7, 2'b01, 0, 0,0, 0,0, 1,0), 12'b00_00_1111_0001};
    for (int i = 0; i < 13; i++) runCycle(vecs[i].s, 1'b1, vecs[i].exp, 1'b0, $sformatf("vec%0d", i));

    // Mul/div held 4 cycles: stall cycles 1-3, busy cycles 2-4
    mdS = z; mdS.mulDivE = 1'b1;
    runCycle(mdS, 1'b1, 12'b00_00_1110_0010, 1'b0, "md_c1");
    runCycle(mdS, 1'b1, 12'b00_00_1110_0010, 1'b1, "md_c2");
    runCycle(mdS, 1'b1, 12'b00_00_1110_0010, 1'b1, "md_c3");
    runCycle(mdS, 1'b1, 12'b00_00_0000_0000, 1'b1, "md_c4");
    runCycle(z,   1'b1, 12'b00_00_0000_0000, 1'b0, "md_done");

    // Memory wait while cnt=1: seven cycles of EX occupancy
    memMd = mdS; memMd.memReqM = 1'b1; memMd.memReadyM = 1'b0;
    runCycle(mdS,   1'b1, 12'b00_00_1110_0010, 1'b0, "mw_c1");
    runCycle(mdS,   1'b1, 12'b00_00_1110_0010, 1'b1, "mw_c2");
    for (int i = 0; i < 3; i++) runCycle(memMd, 1'b1, 12'b00_00_1111_0001, 1'b1, $sformatf("mw_wait%0d", i));
    runCycle(mdS,   1'b1, 12'b00_00_1110_0010, 1'b1, "mw_c6");
    runCycle(mdS,   1'b1, 12'b00_00_0000_0000, 1'b1, "mw_c7");
    runCycle(z,     1'b1, 12'b00_00_0000_0000, 1'b0, "mw_done");

    // Reset in the middle of BUSY
    runCycle(mdS, 1'b0, 12'd0, 1'b0, "rb_c1");
    runCycle(z,   1'b1, 12'b00_00_1110_0010, 1'b1, "rb_c2");
    @(negedge clk);
    drive(z);
    doReset();

    // Ten load-use stalls
    for (int i = 0; i < 10; i++) runCycle(vecs[5].s, 1'b0, 12'd0, 1'b0, "lu");
    runCycle(z, 1'b0, 12'd0, 1'b0, "lu_after");
    check("perf_stall10", StallCycles, PerfEn ? 32'd10 : 32'd0);
    check("perf_flush10", FlushCycles, PerfEn ? 32'd10 : 32'd0);

    // Randomized traffic against the reference model
    for (int i = 0; i < 3000; i++) begin
      s.rs1D = 5'($urandom_range(0, 7)); s.rs2D = 5'($urandom_range(0, 7));
      s.rs1E = 5'($urandom_range(0, 7)); s.rs2E = 5'($urandom_range(0, 7));
      s.rdE  = 5'($urandom_range(0, 7)); s.rdM  = 5'($urandom_range(0, 7));
      s.rdW  = 5'($urandom_range(0, 7));
      s.resultSrcE = 2'($urandom_range(0, 3));
      s.regWriteM = 1'($urandom_range(0, 1)); s.regWriteW = 1'($urandom_range(0, 1));
      s.memReqM   = ($urandom_range(0, 2) == 0); s.memReadyM = 1'($urandom_range(0, 1));
      s.mulDivE   = ($urandom_range(0, 5) == 0);
      s.pcSrcE    = (mdLeft == 0) && !s.mulDivE && ($urandom_range(0, 5) == 0);
      runCycle(s, 1'b0, 12'd0, 1'b0, "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
